// File: rtl/i2s_tx_pkg.sv
// i2s_tx_pkg: shared defaults for the I2S transmitter and its quantizer
package i2s_tx_pkg;
   localparam int SAMPLE_WIDTH  = 24;
   localparam int FIXED_POINT   = 8;
   localparam int I2S_DAC_BITS  = 24;
   localparam int I2S_SLOT_BITS = 32;
   localparam int I2S_BCLK_DIV  = 4;
endpackage

// File: rtl/i2s_tx_sample_quantize.sv
// sample_quantize: arithmetic shift of a fixed-point sample to a saturated signed DAC word
module sample_quantize
   import i2s_tx_pkg::*;
#(
   parameter int IN_WIDTH  = SAMPLE_WIDTH + FIXED_POINT,
   parameter int FRAC_BITS = FIXED_POINT,
   parameter int DAC_BITS  = I2S_DAC_BITS
)(
   input  logic signed [IN_WIDTH-1:0] din,
   output logic        [DAC_BITS-1:0] dout
);
   localparam logic signed [IN_WIDTH-1:0] MAXV = $signed({{(IN_WIDTH-DAC_BITS+1){1'b0}}, {(DAC_BITS-1){1'b1}}});
   localparam logic signed [IN_WIDTH-1:0] MINV = $signed({{(IN_WIDTH-DAC_BITS+1){1'b1}}, {(DAC_BITS-1){1'b0}}});
   logic signed [IN_WIDTH-1:0] q;
   always_comb begin
      q    = din >>> FRAC_BITS;
      dout = q > MAXV ? MAXV[DAC_BITS-1:0] : q < MINV ? MINV[DAC_BITS-1:0] : q[DAC_BITS-1:0];
   end
endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: Philips I2S master transmitter with valid/ready sample intake and underrun repeat
module i2s_tx
   import i2s_tx_pkg::*;
#(
   parameter int IN_WIDTH  = SAMPLE_WIDTH + FIXED_POINT,
   parameter int FRAC_BITS = FIXED_POINT,
   parameter int DAC_BITS  = I2S_DAC_BITS,
   parameter int SLOT_BITS = I2S_SLOT_BITS,
   parameter int BCLK_DIV  = I2S_BCLK_DIV
)(
   input  logic                clk,
   input  logic                rstn,
   input  logic [IN_WIDTH-1:0] left,
   input  logic [IN_WIDTH-1:0] right,
   input  logic                sample_valid,
   output logic                sample_ready,
   output logic                bclk,
   output logic                lrclk,
   output logic                sdata,
   output logic                frame_start,
   output logic                underrun
);
   typedef enum logic {IDLE, RUN} state_t;
   localparam int BW = $clog2(2*SLOT_BITS);
   localparam int DW = $clog2(BCLK_DIV+1);
   localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV-1);
   localparam logic [BW-1:0] BIT_LAST = BW'(2*SLOT_BITS-1);
   localparam logic [BW-1:0] SLOT     = BW'(SLOT_BITS);
   localparam logic [BW-1:0] DBITS    = BW'(DAC_BITS);
   state_t state;
   logic hold_full, fall, active;
   logic [DAC_BITS-1:0] q_l, q_r, hold_l, hold_r, last_l, last_r, sh_l, sh_r;
   logic [DW-1:0] div_cnt;
   logic [BW-1:0] bit_cnt, nxt, j;
   sample_quantize #(.IN_WIDTH(IN_WIDTH), .FRAC_BITS(FRAC_BITS), .DAC_BITS(DAC_BITS)) u_q_l (.din(left),  .dout(q_l));
   sample_quantize #(.IN_WIDTH(IN_WIDTH), .FRAC_BITS(FRAC_BITS), .DAC_BITS(DAC_BITS)) u_q_r (.din(right), .dout(q_r));
   always_comb begin
      fall   = state == RUN && bclk && div_cnt == DIV_LAST;
      nxt    = bit_cnt == BIT_LAST ? '0 : bit_cnt + 1'b1;
      j      = nxt >= SLOT ? nxt - SLOT : nxt;
      active = j != '0 && j <= DBITS;
   end
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state        <= IDLE;
         sample_ready <= 1'b1;
         hold_full    <= 1'b0;
         bclk         <= 1'b0;
         lrclk        <= 1'b0;
         sdata        <= 1'b0;
         frame_start  <= 1'b0;
         underrun     <= 1'b0;
         div_cnt      <= '0;
         bit_cnt      <= '0;
         hold_l       <= '0;
         hold_r       <= '0;
         last_l       <= '0;
         last_r       <= '0;
         sh_l         <= '0;
         sh_r         <= '0;
      end else begin
         frame_start  <= 1'b0;
         underrun     <= 1'b0;
         sample_ready <= !hold_full;
         if (sample_valid && sample_ready && !hold_full) begin
            hold_full <= 1'b1;
            hold_l    <= q_l;
            hold_r    <= q_r;
         end
         if (state == IDLE) begin
            if (hold_full) begin
               state       <= RUN;
               hold_full   <= 1'b0;
               sh_l        <= hold_l;
               sh_r        <= hold_r;
               last_l      <= hold_l;
               last_r      <= hold_r;
               frame_start <= 1'b1;
               div_cnt     <= '0;
               bit_cnt     <= '0;
            end
         end else begin
            div_cnt <= div_cnt == DIV_LAST ? '0 : div_cnt + 1'b1;
            if (div_cnt == DIV_LAST)
               bclk <= !bclk;
            if (fall) begin
               bit_cnt <= nxt;
               lrclk   <= nxt >= SLOT;
               sdata   <= 1'b0;
               // wrap to bit 0: load the next frame, repeating the last pair if nothing is waiting
               if (nxt == '0) begin
                  frame_start <= 1'b1;
                  if (hold_full) begin
                     hold_full <= 1'b0;
                     sh_l      <= hold_l;
                     sh_r      <= hold_r;
                     last_l    <= hold_l;
                     last_r    <= hold_r;
                  end else begin
                     underrun <= 1'b1;
                     sh_l     <= last_l;
                     sh_r     <= last_r;
                  end
               end else if (active) begin
                  if (nxt >= SLOT)
                     {sdata, sh_r} <= {sh_r, 1'b0};
                  else
                     {sdata, sh_l} <= {sh_l, 1'b0};
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: directed vector bench for i2s_tx decoding the serial stream back into DAC words
module tb_i2s_tx;
   localparam int IW = 32, FB = 8, DB = 16, SB = 32, BD = 2, NV = 7;
   logic clk = 1'b0, rstn = 1'b0, sample_valid = 1'b0;
   logic [IW-1:0] left = '0, right = '0;
   logic sample_ready, bclk, lrclk, sdata, frame_start, underrun;
   int checks = 0, failures = 0;
   typedef struct {
      logic [31:0] l, r;
      logic [15:0] el, er;
   } vec_t;
   vec_t v[NV];
   always #5 clk = ~clk;
   i2s_tx #(.IN_WIDTH(IW), .FRAC_BITS(FB), .DAC_BITS(DB), .SLOT_BITS(SB), .BCLK_DIV(BD)) dut (
      .clk(clk), .rstn(rstn), .left(left), .right(right), .sample_valid(sample_valid),
      .sample_ready(sample_ready), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
      .frame_start(frame_start), .underrun(underrun)
   );
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   // decodes one frame starting at a frame_start sample point, optionally offering the next pair
   task automatic recv(input bit offer, input logic [31:0] ol, input logic [31:0] orr,
                       output logic [15:0] gl, output logic [15:0] gr, output int first,
                       output int zbad, output int lbad, output int fs, output int ur,
                       output int rises, output int cyc);
      logic pb, pr;
      int n, idx;
      bit pend;
      gl = '0; gr = '0; first = -1; zbad = 0; lbad = 0; fs = 0; ur = 0; rises = 0; cyc = 0;
      n = 0; pb = bclk; pr = sample_ready; pend = offer;
      while (n < 64 && cyc < 400) begin
         @(negedge clk);
         cyc++;
         sample_valid = 1'b0;
         fs += int'(frame_start);
         ur += int'(underrun);
         if (sample_ready && !pr) rises++;
         pr = sample_ready;
         if (pend && sample_ready) begin
            sample_valid = 1'b1; left = ol; right = orr; pend = 1'b0;
         end
         if (pb && !bclk) begin
            n++;
            idx = n % 64;
            if (first < 0) first = cyc;
            if (lrclk !== (idx >= 32)) lbad++;
            if (idx >= 1 && idx <= 16) gl[16-idx] = sdata;
            else if (idx >= 33 && idx <= 48) gr[48-idx] = sdata;
            else if (sdata !== 1'b0) zbad++;
         end
         pb = bclk;
      end
   endtask
   task automatic check_frame(input string tag, input int k, input logic [15:0] gl, input logic [15:0] gr,
                              input int first, input int zbad, input int lbad, input int fs, input int ur,
                              input int rises, input int cyc, input int exp_ur, input int exp_rises);
      chk({tag, "_left"}, 32'(gl), 32'(v[k].el));
      chk({tag, "_right"}, 32'(gr), 32'(v[k].er));
      chk({tag, "_first_fall"}, first, 4);
      chk({tag, "_period"}, cyc, 256);
      chk({tag, "_pad_zero"}, zbad, 0);
      chk({tag, "_lrclk"}, lbad, 0);
      chk({tag, "_frame_start"}, fs, 1);
      chk({tag, "_underrun"}, ur, exp_ur);
      chk({tag, "_ready_rises"}, rises, exp_rises);
   endtask
   task automatic wait_fs(output int cnt);
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
         sample_valid = 1'b0;
      end while (!frame_start && cnt < 20);
   endtask
   initial begin
      logic [15:0] gl, gr;
      int first, zbad, lbad, fs, ur, rises, cyc, cnt, n;
      logic pb;
      v[0] = '{32'h0012_3400, 32'hFFFF_FF00, 16'h1234, 16'hFFFF};
      v[1] = '{32'h7FFF_FFFF, 32'h8000_0000, 16'h7FFF, 16'h8000};
      v[2] = '{32'h007F_FF00, 32'hFF80_0000, 16'h7FFF, 16'h8000};
      v[3] = '{32'h0080_0000, 32'hFF7F_FF00, 16'h7FFF, 16'h8000};
      v[4] = '{32'h0000_0080, 32'hFFFF_FFFF, 16'h0000, 16'hFFFF};
      v[5] = '{32'h0000_AB00, 32'hFFFF_5500, 16'h00AB, 16'hFF55};
      v[6] = '{32'h0000_0100, 32'hFFFF_FF00, 16'h0001, 16'hFFFF};
      sample_valid = 1'b1; left = v[0].l; right = v[0].r;
      repeat (3) begin
         @(negedge clk);
         chk("reset_outputs", {bclk, lrclk, sdata, frame_start, underrun, sample_ready}, 6'b000001);
      end
      sample_valid = 1'b0; rstn = 1'b1;
      repeat (10) begin
         @(negedge clk);
         chk("idle_outputs", {bclk, lrclk, sdata, frame_start, underrun, sample_ready}, 6'b000001);
      end
      sample_valid = 1'b1;
      wait_fs(cnt);
      chk("first_frame_latency", cnt, 2);
      chk("first_frame_bclk_low", bclk, 0);
      for (int i = 0; i < NV; i++) begin
         recv(i < NV-1, v[(i+1)%NV].l, v[(i+1)%NV].r, gl, gr, first, zbad, lbad, fs, ur, rises, cyc);
         check_frame($sformatf("stream%0d", i), i, gl, gr, first, zbad, lbad, fs, ur, rises, cyc,
                     i == NV-1 ? 1 : 0, 1);
      end
      for (int i = 0; i < 2; i++) begin
         recv(1'b0, '0, '0, gl, gr, first, zbad, lbad, fs, ur, rises, cyc);
         check_frame($sformatf("repeat%0d", i), NV-1, gl, gr, first, zbad, lbad, fs, ur, rises, cyc, 1, 0);
      end
      n = 0; cnt = 0; pb = bclk;
      while (n < 40 && cnt < 400) begin
         @(negedge clk);
         cnt++;
         if (pb && !bclk) n++;
         pb = bclk;
      end
      chk("bclk40_reached", n, 40);
      chk("bclk40_lrclk_high", lrclk, 1);
      chk("bclk40_sdata", sdata, 1);
      rstn = 1'b0;
      @(negedge clk);
      chk("midreset_outputs", {bclk, lrclk, sdata, frame_start, underrun, sample_ready}, 6'b000001);
      rstn = 1'b1;
      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         cnt += int'(bclk) + int'(lrclk) + int'(sdata) + int'(frame_start) + int'(underrun) + int'(!sample_ready);
      end
      chk("post_reset_idle", cnt, 0);
      sample_valid = 1'b1; left = v[1].l; right = v[1].r;
      wait_fs(cnt);
      chk("restart_latency", cnt, 2);
      recv(1'b0, '0, '0, gl, gr, first, zbad, lbad, fs, ur, rises, cyc);
      check_frame("restart", 1, gl, gr, first, zbad, lbad, fs, ur, rises, cyc, 1, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
Serialises the stereo fixed-point output of the panning stage (left/right signed samples) to a standard Philips I2S stream for the board DAC. Each sample is converted from internal fixed point to a signed DAC word by arithmetic shift and saturation. The block generates BCLK/LRCLK as clock master and sends data MSB-first. It sits at the end of the audio chain, after pan, and accepts samples through a valid/ready handshake.

Parameters:
IN_WIDTH, `SAMPLE_WIDTH + `FIXED_POINT, width of signed fixed-point input samples
FRAC_BITS, `FIXED_POINT, fractional bits in input samples
DAC_BITS, 24, signed word width sent to DAC; requires DAC_BITS <= IN_WIDTH-FRAC_BITS
SLOT_BITS, 32, BCLK periods per channel slot; requires SLOT_BITS > DAC_BITS
BCLK_DIV, 4, clk cycles per BCLK half-period (>=1)

Ports:
clk  in  1  system clock
rstn  in  1  synchronous active-low reset
left  in  IN_WIDTH  signed fixed-point left sample
right  in  IN_WIDTH  signed fixed-point right sample
sample_valid  in  1  left/right pair valid
sample_ready  out  1  holding register empty; pair accepted when valid && ready
bclk  out  1  bit clock to DAC
lrclk  out  1  word select; 0 = left slot, 1 = right slot
sdata  out  1  serial data, changes only on bclk falling edge
frame_start  out  1  one-cycle pulse when a new frame loads into the shifters
underrun  out  1  one-cycle pulse when a frame starts with no new pair (previous pair repeated)

Behaviour:
- Reset (rstn=0 at a clk edge): state IDLE; bclk=0, lrclk=0, sdata=0, frame_start=0, underrun=0, sample_ready=1; holding register empty; shifters, div_cnt, bit_cnt and the last-pair register are 0.
- Conversion: q = in >>> FRAC_BITS (arithmetic shift). If q > 2^(DAC_BITS-1)-1, send the max. If q < -2^(DAC_BITS-1), send the min. Otherwise send q[DAC_BITS-1:0].
- Handshake: a pair is captured into the holding register when sample_valid && sample_ready. sample_ready is the registered value of "holding empty". It drops the cycle after acceptance and rises the cycle after the holding register is transferred to the shifters. When the holding register is full, left and right are ignored.
- IDLE: bclk, lrclk and sdata are held at 0. The first accepted pair moves the state to RUN. That pair is transferred directly to the shifters on the next cycle, with frame_start=1, div_cnt=0 and bit_cnt=0.
- RUN: div_cnt counts 0..BCLK_DIV-1; bclk toggles on wrap.
  - On each bclk falling edge, bit_cnt advances modulo 2*SLOT_BITS. lrclk = (bit_cnt >= SLOT_BITS).
  - Slot position j = bit_cnt mod SLOT_BITS. sdata = 0 for j=0 (one-BCLK I2S delay). For j=1..DAC_BITS, sdata = word bit DAC_BITS-j (MSB first). For the rest of the slot, sdata = 0.
  - When bit_cnt wraps to 0, a new frame starts:
    - If the holding register is full, it moves to the shifters and to the last-pair register, and frame_start pulses.
    - Otherwise the last pair is reloaded, and frame_start and underrun both pulse.
- Frame period: 2*SLOT_BITS*2*BCLK_DIV clk cycles.
- Simultaneous events: if a transfer and a new valid coincide, the new pair is not accepted that cycle, because sample_ready is still 0.
- Reset mid-frame: outputs return to reset values on the next edge and the partial frame is abandoned.
- The block never returns to IDLE except through reset.

Decomposition:
- Add `DAC_BITS, `I2S_SLOT_BITS and `I2S_BCLK_DIV defaults to constants.svh, next to `SAMPLE_WIDTH and `FIXED_POINT.
- Define the IDLE/RUN state enum locally in the module.
- One natural sub-module: sample_quantize, a combinational shift+saturate block with parameters IN_WIDTH, FRAC_BITS and DAC_BITS. It is instantiated twice, once for left and once for right.

Test Plan:
(Bench overrides: IN_WIDTH=32, FRAC_BITS=8, DAC_BITS=16, SLOT_BITS=32, BCLK_DIV=2, so frame = 256 clk.)
- Reset: hold rstn=0 for 3 cycles with valid=1 -> bclk=lrclk=sdata=0, sample_ready=1, no frame_start; state stays IDLE.
- First pair left=0x00123400, right=0xFFFFFF00 -> frame_start 2 cycles after accept. First bclk fall at +4 clk with sdata=MSB. Left slot shifts 0x1234 MSB-first; right slot shifts 0xFFFF (-1). lrclk goes high at BCLK 32.
- Saturation: left=0x7FFFFFFF, right=0x80000000 -> DAC words 0x7FFF and 0x8000.
- Streaming: a new pair is offered each frame -> sample_ready pulses low/high once per 256 clk, with no underrun over 4 frames and each frame carrying the correct pair.
- Underrun: stop valid after one pair -> the next frame repeats the pair bit-exactly and underrun pulses exactly once per frame.
- Reset mid-frame at BCLK 40 -> outputs are 0 next cycle; after release the block stays IDLE until valid.
